// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared encodings for the NeoPixel sequencer.
// Line states, sequencer FSM encoding and sizing helpers.
package anton_neopixel_sequencer_pkg;

  localparam int BUFFER_END_DEFAULT = 63;

  localparam logic STATE_TRANSMIT = 1'b1;
  localparam logic STATE_RESET = 1'b0;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RESET_WAIT = 2'd1,
    SEQ_TRANSMIT = 2'd2
  } seqState_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/anton_neopixel_slot_counter.sv
// Slot prescaler, bit-pattern slot and bit-within-pixel cascade.
// pixelCarry flags the edge on which the last slot of a pixel ends.
module anton_neopixel_slot_counter #(
  parameter int SLOT_CLOCKS = 1
) (
  input  logic       clk,
  input  logic       syncResetN,
  input  logic       enable,
  input  logic       clear,
  output logic [2:0] bitPatternIndex,
  output logic [4:0] pixelBitIndex,
  output logic       pixelCarry
);

  localparam int PW =
    (SLOT_CLOCKS > 1) ? $clog2(SLOT_CLOCKS) : 1;
  localparam int SLOT_LAST_I = SLOT_CLOCKS - 1;
  localparam logic [PW-1:0] SLOT_LAST =
    SLOT_LAST_I[PW-1:0];

  logic [PW-1:0] prescale;
  logic slotTick;
  logic bitTick;

  assign slotTick = enable && (prescale == SLOT_LAST);
  assign bitTick = slotTick && (bitPatternIndex == 3'd7);
  assign pixelCarry = bitTick && (pixelBitIndex == 5'd23);

  always_ff @(posedge clk) begin
    if (!syncResetN || clear) begin
      prescale <= '0;
      bitPatternIndex <= '0;
      pixelBitIndex <= '0;
    end else if (enable) begin
      prescale <= slotTick ? '0 : prescale + 1'b1;
      if (slotTick)
        bitPatternIndex <= bitPatternIndex + 3'd1;
      if (bitTick)
        pixelBitIndex <= (pixelBitIndex == 5'd23) ?
          5'd0 : pixelBitIndex + 5'd1;
    end
  end

endmodule

// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: frame FSM, pixel index and latch gap.
// Frame controls are shadowed at frame start.
module anton_neopixel_sequencer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int BUFFER_END = BUFFER_END_DEFAULT,
  parameter int SLOT_CLOCKS = 1,
  parameter int RESET_CLOCKS = 400,
  localparam int BUFFER_BITS = clog2(BUFFER_END + 1)
) (
  input  logic                   clk,
  input  logic                   syncResetN,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrl32bit,
  input  logic                   regCtrlLimit,
  input  logic [BUFFER_BITS-1:0] regMax,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [4:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic                   streamSync,
  output logic                   regCtrlRunClear
);

  localparam int GW =
    (RESET_CLOCKS > 1) ? $clog2(RESET_CLOCKS) : 1;
  localparam int GAP_LAST_I = RESET_CLOCKS - 1;
  localparam logic [GW-1:0] GAP_LAST =
    GAP_LAST_I[GW-1:0];
  localparam logic [BUFFER_BITS-1:0] END_IDX =
    BUFFER_END[BUFFER_BITS-1:0];
  localparam logic [BUFFER_BITS-1:0] STEP1 =
    BUFFER_BITS'(1);
  localparam logic [BUFFER_BITS-1:0] STEP4 =
    BUFFER_BITS'(4);

  seqState_t cur;
  seqState_t nxt;

  logic [GW-1:0] gapCnt;
  logic gapDone;
  logic afterFrame;
  logic shadow32;
  logic shadowLimit;
  logic [BUFFER_BITS-1:0] shadowMax;
  logic [BUFFER_BITS-1:0] lastIdx;
  logic lastPixel;
  logic pixelCarry;
  logic slotEnable;
  logic slotClear;
  logic abortFrame;
  logic frameEnd;
  logic frameStart;
  logic syncNext;
  logic runClearNext;

  assign gapDone =
    (cur == SEQ_RESET_WAIT) && (gapCnt == GAP_LAST);
  // regMax beyond the buffer clamps to the buffer end
  assign lastIdx =
    (shadowLimit && (shadowMax < END_IDX)) ?
    shadowMax : END_IDX;
  assign lastPixel = shadow32 ?
    ((pixelIndex >> 2) == (lastIdx >> 2)) :
    (pixelIndex == lastIdx);
  assign abortFrame = (cur == SEQ_TRANSMIT) && !regCtrlRun;
  assign frameEnd = pixelCarry && lastPixel;
  assign frameStart =
    (nxt == SEQ_TRANSMIT) && (cur != SEQ_TRANSMIT);
  assign slotEnable = (cur == SEQ_TRANSMIT) && regCtrlRun;
  assign slotClear = (nxt != SEQ_TRANSMIT);

  anton_neopixel_slot_counter #(
    .SLOT_CLOCKS(SLOT_CLOCKS)
  ) slotCounter (
    .clk(clk),
    .syncResetN(syncResetN),
    .enable(slotEnable),
    .clear(slotClear),
    .bitPatternIndex(bitPatternIndex),
    .pixelBitIndex(pixelBitIndex),
    .pixelCarry(pixelCarry)
  );

  always_ff @(posedge clk) begin
    if (!syncResetN) cur <= SEQ_RESET_WAIT;
    else cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      SEQ_RESET_WAIT:
        if (gapDone)
          nxt = regCtrlRun ? SEQ_TRANSMIT : SEQ_IDLE;
      SEQ_IDLE:
        if (regCtrlRun) nxt = SEQ_TRANSMIT;
      SEQ_TRANSMIT:
        if (abortFrame || frameEnd) nxt = SEQ_RESET_WAIT;
      default: nxt = SEQ_RESET_WAIT;
    endcase
  end

  always_comb begin
    state = STATE_RESET;
    syncNext = 1'b0;
    runClearNext = 1'b0;
    unique case (1'b1)
      cur == SEQ_TRANSMIT: begin
        state = STATE_TRANSMIT;
        runClearNext = frameEnd && !regCtrlLoop;
      end
      gapDone: syncNext = afterFrame;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!syncResetN) begin
      gapCnt <= '0;
      afterFrame <= 1'b0;
      shadow32 <= 1'b0;
      shadowLimit <= 1'b0;
      shadowMax <= '0;
      pixelIndex <= '0;
      streamSync <= 1'b0;
      regCtrlRunClear <= 1'b0;
    end else begin
      streamSync <= syncNext;
      regCtrlRunClear <= runClearNext;
      gapCnt <= (cur == SEQ_RESET_WAIT && !gapDone) ?
        gapCnt + 1'b1 : '0;
      if (cur == SEQ_TRANSMIT && nxt == SEQ_RESET_WAIT)
        afterFrame <= 1'b1;
      else if (gapDone)
        afterFrame <= 1'b0;
      if (frameStart) begin
        shadow32 <= regCtrl32bit;
        shadowLimit <= regCtrlLimit;
        shadowMax <= regMax;
      end
      if (nxt != SEQ_TRANSMIT)
        pixelIndex <= '0;
      else if (pixelCarry)
        pixelIndex <= pixelIndex +
          (shadow32 ? STEP4 : STEP1);
    end
  end

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Scoreboard bench for anton_neopixel_sequencer.
// Random frames checked against an arithmetic timing model.
module tb_anton_neopixel_sequencer;

  localparam int BE = 5;
  localparam int SC = 2;
  localparam int RC = 10;
  localparam int BB = 3;

  logic clk = 1'b0;
  logic syncResetN = 1'b0;
  logic regCtrlRun = 1'b0;
  logic regCtrlLoop = 1'b0;
  logic regCtrl32bit = 1'b0;
  logic regCtrlLimit = 1'b0;
  logic [BB-1:0] regMax = '0;
  logic state;
  logic [BB-1:0] pixelIndex;
  logic [4:0] pixelBitIndex;
  logic [2:0] bitPatternIndex;
  logic streamSync;
  logic regCtrlRunClear;

  always #5 clk = ~clk;

  anton_neopixel_sequencer #(
    .BUFFER_END(BE),
    .SLOT_CLOCKS(SC),
    .RESET_CLOCKS(RC)
  ) dut (
    .clk(clk),
    .syncResetN(syncResetN),
    .regCtrlRun(regCtrlRun),
    .regCtrlLoop(regCtrlLoop),
    .regCtrl32bit(regCtrl32bit),
    .regCtrlLimit(regCtrlLimit),
    .regMax(regMax),
    .state(state),
    .pixelIndex(pixelIndex),
    .pixelBitIndex(pixelBitIndex),
    .bitPatternIndex(bitPatternIndex),
    .streamSync(streamSync),
    .regCtrlRunClear(regCtrlRunClear)
  );

  typedef struct {
    int start;
    int len;
    bit clr;
    int step;
  } frame_t;

  frame_t frameQ[$];
  int syncQ[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int frameLen(input bit is32,
                                  input bit lim,
                                  input int mx);
    int e;
    int ord;
    e = lim ? ((mx > BE) ? BE : mx) : BE;
    ord = is32 ? e / 4 : e;
    return (ord + 1) * 24 * 8 * SC;
  endfunction

  function automatic frame_t mk(input int s, input int l,
                                input bit c, input bit is32);
    frame_t f;
    f.start = s;
    f.len = l;
    f.clr = c;
    f.step = is32 ? 4 : 1;
    return f;
  endfunction

  // monitor
  bit prevState = 1'b0;
  bit active = 1'b0;
  frame_t curF;
  int t = 0;
  int idxBad = 0;
  int lastFall = -1000;
  int strayClear = 0;
  int idleBad = 0;

  always @(negedge clk) begin
    int s;
    if (state && !prevState) begin
      check("frame_expected", int'(frameQ.size() > 0), 1);
      if (frameQ.size() > 0) begin
        curF = frameQ.pop_front();
        check("frame_start", cyc, curF.start);
        active = 1'b1;
      end
      t = 0;
      idxBad = 0;
    end
    if (state) begin
      if (active) begin
        s = t / SC;
        if (int'(bitPatternIndex) != s % 8 ||
            int'(pixelBitIndex) != (s / 8) % 24 ||
            int'(pixelIndex) != (s / 192) * curF.step)
          idxBad++;
      end
      t++;
    end else if (pixelIndex != 0 || pixelBitIndex != 0 ||
                 bitPatternIndex != 0) begin
      idleBad++;
    end
    if (!state && prevState) begin
      lastFall = cyc;
      if (active) begin
        check("frame_len", t, curF.len);
        check("run_clear", int'(regCtrlRunClear),
              int'(curF.clr));
        check("index_seq", idxBad, 0);
      end
      active = 1'b0;
    end else if (regCtrlRunClear) begin
      strayClear++;
    end
    if (streamSync) begin
      check("sync_expected", int'(syncQ.size() > 0), 1);
      if (syncQ.size() > 0) begin
        void'(syncQ.pop_front());
        check("sync_gap", cyc - lastFall, RC);
      end
    end
    prevState = state;
  end

  // stimulus
  task automatic waitTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setCfg();
    regCtrl32bit = 1'($urandom_range(0, 1));
    regCtrlLimit = 1'($urandom_range(0, 1));
    regMax = BB'($urandom_range(0, 7));
  endtask

  task automatic singleFrame(input bit rnd);
    int s;
    int l;
    if (rnd) setCfg();
    regCtrlLoop = 1'b0;
    l = frameLen(regCtrl32bit, regCtrlLimit, int'(regMax));
    s = cyc + 1;
    frameQ.push_back(mk(s, l, 1'b1, regCtrl32bit));
    syncQ.push_back(1);
    regCtrlRun = 1'b1;
    waitTo(s + int'($urandom_range(1, l - 2)));
    setCfg();
    waitTo(s + l + 1);
    regCtrlRun = 1'b0;
    waitTo(s + l + 12);
  endtask

  task automatic loopFrames();
    int s;
    int n;
    int l;
    int l2;
    setCfg();
    regCtrlLoop = 1'b1;
    n = int'($urandom_range(2, 3));
    l = frameLen(regCtrl32bit, regCtrlLimit, int'(regMax));
    s = cyc + 1;
    frameQ.push_back(mk(s, l, 1'b0, regCtrl32bit));
    syncQ.push_back(1);
    regCtrlRun = 1'b1;
    waitTo(s + int'($urandom_range(1, l - 2)));
    setCfg();
    l2 = frameLen(regCtrl32bit, regCtrlLimit, int'(regMax));
    s = s + l + RC;
    for (int k = 1; k < n; k++) begin
      frameQ.push_back(mk(s, l2, 1'b0, regCtrl32bit));
      syncQ.push_back(1);
      if (k < n - 1) s = s + l2 + RC;
    end
    waitTo(s + l2 + 2);
    regCtrlRun = 1'b0;
    waitTo(s + l2 + 14);
    regCtrlLoop = 1'b0;
  endtask

  task automatic abortFrame(input bit doReset);
    int s;
    int l;
    int a;
    setCfg();
    regCtrlLoop = 1'($urandom_range(0, 1));
    l = frameLen(regCtrl32bit, regCtrlLimit, int'(regMax));
    a = int'($urandom_range(0, l - 2));
    s = cyc + 1;
    frameQ.push_back(mk(s, a + 1, 1'b0, regCtrl32bit));
    if (!doReset) syncQ.push_back(1);
    regCtrlRun = 1'b1;
    waitTo(s + a);
    regCtrlRun = 1'b0;
    if (doReset) syncResetN = 1'b0;
    waitTo(s + a + 1);
    syncResetN = 1'b1;
    waitTo(s + a + 14);
    regCtrlLoop = 1'b0;
  endtask

  initial begin
    int r;
    syncResetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    syncResetN = 1'b1;
    r = cyc;
    check("reset_state", int'(state), 0);
    check("reset_pixel", int'(pixelIndex), 0);
    waitTo(r + 9);
    check("gap_state", int'(state), 0);
    waitTo(r + 14);
    check("idle_state", int'(state), 0);

    regCtrl32bit = 1'b0;
    regCtrlLimit = 1'b0;
    singleFrame(1'b0);
    regCtrl32bit = 1'b1;
    regCtrlLimit = 1'b1;
    regMax = 3'd7;
    singleFrame(1'b0);
    regCtrl32bit = 1'b0;
    regMax = 3'd2;
    singleFrame(1'b0);

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: singleFrame(1'b1);
        1: loopFrames();
        2: abortFrame(1'b0);
        default: abortFrame(1'b1);
      endcase
    end

    waitTo(cyc + 20);
    check("frames_left", frameQ.size(), 0);
    check("syncs_left", syncQ.size(), 0);
    check("stray_run_clear", strayClear, 0);
    check("idle_indices", idleBad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_sequencer.md
Name: anton_neopixel_sequencer

Overview:
Cycle-accurate timing controller for the NeoPixel stream datapath. It generates the frame state, the pixel index, the bit-within-pixel index and the pattern-slot index that the stream encoder consumes, and it inserts the latch/reset gap between frames. It handles single-shot and looping refresh, an optional pixel-count limit, and 8-bit versus 32-bit pixel addressing. It sits between the register file (control bits) and the stream encoder (index inputs).

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, highest byte index of the pixel buffer
BUFFER_BITS, `CLOG2(BUFFER_END+1), localparam, width of index and limit registers
SLOT_CLOCKS, 1, clocks per pattern slot (8 slots = 1 NeoPixel bit, ~1.25 us total)
RESET_CLOCKS, 400, clocks the line is held in reset/latch (>= 50 us at ~6.4 MHz)

Ports:
clk  in  1  system clock
syncResetN  in  1  synchronous, active-low reset
regCtrlRun  in  1  enable streaming
regCtrlLoop  in  1  1 = refresh continuously; 0 = send one frame, then clear run
regCtrl32bit  in  1  1 = 4 bytes per pixel, index steps by 4; 0 = 1 byte per pixel
regCtrlLimit  in  1  1 = last byte index is regMax; 0 = last byte index is BUFFER_END
regMax  in  BUFFER_BITS  last byte index when regCtrlLimit is 1
state  out  1  `ENUM_STATE_TRANSMIT while sending, otherwise `ENUM_STATE_RESET
pixelIndex  out  BUFFER_BITS  byte index of the current pixel
pixelBitIndex  out  5  0..23, bit within the pixel
bitPatternIndex  out  3  0..7, slot within the bit pattern
streamSync  out  1  one-clock pulse at the end of every reset gap that follows a frame
regCtrlRunClear  out  1  one-clock pulse asking the register file to clear regCtrlRun

Behaviour:
- Internal FSM with three states. Only TRANSMIT drives state=`ENUM_STATE_TRANSMIT`.
  - RESET_WAIT: count RESET_CLOCKS.
  - IDLE.
  - TRANSMIT.
- Reset (syncResetN=0 at a clk edge):
  - FSM goes to RESET_WAIT.
  - All counters, pixelIndex, pixelBitIndex and bitPatternIndex are cleared to 0.
  - streamSync and regCtrlRunClear are 0.
  - state=RESET.
- RESET_WAIT:
  - The gap counter runs 0..RESET_CLOCKS-1.
  - On the terminal count: if the gap followed a frame, pulse streamSync for 1 clk.
  - Then go to TRANSMIT if regCtrlRun=1, else go to IDLE.
  - The gap that follows syncResetN gives no streamSync.
- IDLE: stay in IDLE while regCtrlRun=0. On regCtrlRun=1, go to TRANSMIT on the next clk with all indices at 0.
- Frame start (entry to TRANSMIT): latch regCtrl32bit, regCtrlLimit and regMax into a frame-shadow register. Changes to these during a frame take effect at the next frame.
- TRANSMIT counter cascade:
  - The slot prescaler counts 0..SLOT_CLOCKS-1.
  - On its terminal count, bitPatternIndex increments; 7 wraps to 0 and carries.
  - The carry increments pixelBitIndex; 23 wraps to 0 and carries.
  - The pixel carry adds 1 to pixelIndex (4 when 32-bit is latched).
  - All outputs are registered, so indices change on the clk edge after the terminal count.
- Last pixel:
  - Let E = regMax when the latched limit is 1, else BUFFER_END.
  - 8-bit mode: the pixel is last when pixelIndex==E.
  - 32-bit mode: the pixel is last when pixelIndex[BUFFER_BITS-1:2]==E[BUFFER_BITS-1:2].
  - On the pixel carry of the last pixel, go to RESET_WAIT with indices cleared.
  - If regCtrlLoop=0 at that edge, pulse regCtrlRunClear for 1 clk.
- Frame length: (lastPixelOrdinal+1) * 24 * 8 * SLOT_CLOCKS clocks. lastPixelOrdinal is E in 8-bit mode and E>>2 in 32-bit mode.
- regCtrlRun dropping to 0 mid-frame:
  - Abort on the next clk: go to RESET_WAIT with indices cleared.
  - The gap does run; streamSync does pulse; regCtrlRunClear does not pulse.
- regCtrlRun=1 with regCtrlLoop=1: back-to-back frames, each separated by exactly RESET_CLOCKS clocks.
- regMax > BUFFER_END: clamp E to BUFFER_END.
- syncResetN takes precedence over every other event, including mid-frame.

Decomposition:
- Shared header (anton_common.vh) holds:
  - `ENUM_STATE_TRANSMIT / `ENUM_STATE_RESET.
  - A new `ENUM_SEQ_IDLE / RESET_WAIT / TRANSMIT FSM encoding.
  - `CLOG2 and `BUFFER_END_DEFAULT.
- One natural sub-module, anton_neopixel_slot_counter: the prescaler, bitPatternIndex and pixelBitIndex cascade, with enable, clear and carry-out. The FSM and pixelIndex logic stay in the parent.

Test Plan:
- Reset release: BUFFER_END=3, SLOT_CLOCKS=1, RESET_CLOCKS=10, run=0 -> state=RESET for 10 clk, then IDLE; no streamSync; all indices 0.
- Single frame, 8-bit: run=1, loop=0, limit=0 ->
  - TRANSMIT lasts 768 clk (4x192).
  - pixelIndex steps 0,1,2,3 every 192 clk.
  - regCtrlRunClear pulses on the last edge.
  - streamSync pulses 10 clk later.
  - FSM ends in IDLE.
- 32-bit + limit: BUFFER_END=15, regMax=9, 32bit=1 -> pixelIndex takes values 0,4,8; frame is 576 clk.
- Loop with SLOT_CLOCKS=2: loop=1 -> bitPatternIndex holds each value 2 clk; frames of 1536 clk separated by exactly 10 clk gaps; no regCtrlRunClear.
- Abort: drop run at clk 300 of a frame -> state=RESET next clk; gap of 10 clk; streamSync pulses; IDLE; no run-clear pulse.
- Mid-frame reset and shadowing:
  - syncResetN=0 at clk 100 -> next edge: indices 0, state=RESET.
  - regMax changed mid-frame -> the current frame length is unchanged.
